// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file write, read, scoreboard and scrub signals
interface regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                   wr0_en;
  logic [AW-1:0]          wr0_addr;
  logic [XLEN-1:0]        wr0_data;
  logic                   wr1_en;
  logic [AW-1:0]          wr1_addr;
  logic [XLEN-1:0]        wr1_data;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   sb_set_en;
  logic [AW-1:0]          sb_set_addr;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_addr, sb_set_en, sb_set_addr, clr_req,
    input  rd_data, rd_busy, clr_busy, clr_done
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_addr, sb_set_en, sb_set_addr, clr_req,
    output rd_data, rd_busy, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with scoreboard and scrub engine
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        idx, idx_nxt;
  logic [XLEN-1:0]      regs [NUM_REGS];
  logic [NUM_REGS-1:0]  busy, busy_nxt;
  logic                 clearing;
  logic                 wr0_act, wr1_act, set_act;

  // Ports are frozen while the scrub walks the array; register 0 is never a target.
  assign clearing = (state == CLEAR);
  assign wr0_act  = bus.wr0_en    && !clearing && (bus.wr0_addr    != '0);
  assign wr1_act  = bus.wr1_en    && !clearing && (bus.wr1_addr    != '0);
  assign set_act  = bus.sb_set_en && !clearing && (bus.sb_set_addr != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      idx   <= AW'(1);
      busy  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
    end
  end

  // Port 1 is written last so it owns a same-address collision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clearing) begin
      regs[idx] <= '0;
    end else begin
      if (wr0_act) regs[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_act) regs[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    bus.clr_busy = 1'b0;
    bus.clr_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = AW'(1);
        end
      end
      CLEAR: begin
        bus.clr_busy = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
          idx_nxt   = AW'(1);
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        bus.clr_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new in-flight mark beats a retiring write to the same register.
  always_comb begin
    busy_nxt = busy;
    if (state == DONE) busy_nxt = '0;
    if (wr0_act) busy_nxt[bus.wr0_addr] = 1'b0;
    if (wr1_act) busy_nxt[bus.wr1_addr] = 1'b0;
    if (set_act) busy_nxt[bus.sb_set_addr] = 1'b1;
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rdat;
  logic            hit;

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    rdat        = '0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = bus.rd_addr[k*AW +: AW];
      rdat = regs[ra];
      hit  = 1'b0;
      if (BYPASS) begin
        if (wr1_act && (bus.wr1_addr == ra)) begin
          rdat = bus.wr1_data;
          hit  = 1'b1;
        end else if (wr0_act && (bus.wr0_addr == ra)) begin
          rdat = bus.wr0_data;
          hit  = 1'b1;
        end
      end
      if (ra == '0) rdat = '0;
      bus.rd_data[k*XLEN +: XLEN] = rdat;
      bus.rd_busy[k]              = busy[ra] & ~hit;
    end
  end
endmodule
